// File: rtl/priority_arbiter_if.sv
// Request/grant bundle for priority_arbiter.
//   master : requester side -- drives req, mode, ack; observes the grant.
//   slave  : arbiter side   -- observes req, mode, ack; drives the grant.
// Signals:
//   req        [N-1:0]  request vector, bit i = requester i
//   mode                0 = fixed priority (bit 0 highest), 1 = round-robin
//   ack                 consumer accepts the current grant
//   gnt_valid           a grant is presented
//   gnt_code   [W-1:0]  binary index of the granted requester
//   gnt_onehot [N-1:0]  one-hot form of gnt_code, zero when no grant
interface priority_arbiter_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
);
    logic [N-1:0] req;
    logic         mode;
    logic         ack;
    logic         gnt_valid;
    logic [W-1:0] gnt_code;
    logic [N-1:0] gnt_onehot;

    modport master (
        output req, mode, ack,
        input  gnt_valid, gnt_code, gnt_onehot
    );

    modport slave (
        input  req, mode, ack,
        output gnt_valid, gnt_code, gnt_onehot
    );
endinterface

// File: rtl/priority_arbiter.sv
// Registered N-way arbiter with fixed-priority and round-robin modes.
// A grant is held unchanged until acked; on an ack the arbiter re-arbitrates
// in the same cycle so back-to-back grants carry no idle bubble.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (grant dropped, ptr cleared)
//   bus  : priority_arbiter_if.slave (req/mode/ack in, gnt_* out)
module priority_arbiter #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input logic               clk,
    input logic               rst,
    priority_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] code_q, code_d;

    logic         ack_take;
    logic         any_req;
    logic [W-1:0] fix_win;
    logic [W-1:0] rr_win;
    logic [W-1:0] win;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            code_q  <= code_d;
        end
    end

    // Round-robin pointer: advances past the acked winner only in
    // round-robin mode; the arbiter below searches from this updated value.
    always_comb begin
        ack_take = (state_q == GRANT) && bus.ack;
        ptr_d    = ptr_q;
        if (ack_take && bus.mode) begin
            ptr_d = (code_q == W'(N - 1)) ? '0 : code_q + W'(1);
        end
    end

    // Winner selection for both modes
    always_comb begin
        logic         fix_found;
        logic         rr_found;
        logic [W-1:0] idx;

        fix_win   = '0;
        fix_found = 1'b0;
        rr_win    = '0;
        rr_found  = 1'b0;
        idx       = '0;

        for (int unsigned i = 0; i < N; i++) begin
            if (!fix_found && bus.req[W'(i)]) begin
                fix_win   = W'(i);
                fix_found = 1'b1;
            end
        end

        for (int unsigned i = 0; i < N; i++) begin
            idx = W'((32'(ptr_d) + i) % N);
            if (!rr_found && bus.req[idx]) begin
                rr_win   = idx;
                rr_found = 1'b1;
            end
        end

        any_req = |bus.req;
        win     = bus.mode ? rr_win : fix_win;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    code_d  = win;
                end
            end
            GRANT: begin
                if (bus.ack) begin
                    if (any_req) begin
                        code_d = win;
                    end else begin
                        state_d = IDLE;
                        code_d  = '0;
                    end
                end
            end
        endcase
    end

    // Output logic
    always_comb begin
        bus.gnt_valid  = (state_q == GRANT);
        bus.gnt_code   = '0;
        bus.gnt_onehot = '0;
        if (state_q == GRANT) begin
            bus.gnt_code   = code_q;
            bus.gnt_onehot = N'(1) << code_q;
        end
    end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, number of request lines (legal 2..32).
REQ-002 SHALL have derived parameter W, default $clog2(N), grant code width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  N  request vector; bit i = requester i.
REQ-006 SHALL have port mode  input  1  0 = fixed priority (bit 0 highest), 1 = round-robin.
REQ-007 SHALL have port ack  input  1  consumer accepts the current grant.
REQ-008 SHALL have port gnt_valid  output  1  a grant is presented.
REQ-009 SHALL have port gnt_code  output  W  binary index of the granted requester.
REQ-010 SHALL have port gnt_onehot  output  N  one-hot form of gnt_code; all zero when gnt_valid=0.

Function
REQ-011 SHALL implement two states: IDLE (gnt_valid=0) and GRANT (gnt_valid=1).
REQ-012 SHALL, in IDLE with any req bit set, select a winner and enter GRANT on the next edge; latency req-to-gnt_valid is 1 cycle.
REQ-013 SHALL, in IDLE with req all zero, stay in IDLE with gnt_code=0 and gnt_onehot=0; outputs are never X.
REQ-014 SHALL, in fixed mode, select the lowest-index set req bit.
REQ-015 SHALL, in round-robin mode, select the first set req bit at or above pointer ptr, searching upward and wrapping from N-1 to 0.
REQ-016 SHALL hold gnt_code, gnt_onehot and gnt_valid stable in GRANT until ack=1 is sampled, even if the granted req bit drops or higher-priority bits rise.
REQ-017 SHALL, on ack=1 in GRANT, set ptr to (gnt_code+1) mod N; N-1 wraps to 0.
REQ-018 SHALL leave ptr unchanged on acks in fixed mode; ptr is still maintained so a switch to round-robin resumes from it.
REQ-019 SHALL, on ack=1 in GRANT, rearbitrate in the same cycle using the current req and the updated ptr: if any req bit is set, stay in GRANT with the new winner on the next edge (back-to-back, no bubble); otherwise go to IDLE.
REQ-020 SHALL ignore ack when gnt_valid=0.
REQ-021 SHALL sample mode only at arbitration instants (IDLE with requests, or an ack in GRANT); a mode change during a held grant takes effect at the next arbitration.
REQ-022 SHALL keep gnt_onehot equal to (1 << gnt_code) whenever gnt_valid=1.

Reset
REQ-023 SHALL, while rst=1, force state=IDLE, ptr=0, gnt_valid=0, gnt_code=0 and gnt_onehot=0 immediately, without waiting for a clock edge.
REQ-024 SHALL abandon any held grant when reset is asserted mid-grant, with no ack-side effects; after rst deasserts, arbitration restarts from ptr=0 on the first edge with requests.

Verification (N=8)
REQ-025 SHALL be verified with the following scenario: reset, mode=0, req=8'b1010_0100 for 1 cycle -> next cycle gnt_valid=1, gnt_code=2, gnt_onehot=8'h04; stays held with ack=0 while req changes to 8'h01.
REQ-026 SHALL be verified with the following scenario: mode=1, req=8'hFF, ack=1 every cycle -> gnt_code sequence 0,1,2,...,7,0 with gnt_valid continuously 1.
REQ-027 SHALL be verified with the following scenario: mode=1, ptr at 6 (after grant 5 acked), req=8'b0000_1001 -> gnt_code=0 (wrap), then with ack -> gnt_code=3.
REQ-028 SHALL be verified with the following scenario: GRANT code=4, ack=1 and req=0 in the same cycle -> next cycle gnt_valid=0, gnt_code=0, gnt_onehot=0; ack=1 in IDLE -> no state or ptr change.
REQ-029 SHALL be verified with the following scenario: GRANT held with code=3, rst pulsed between clock edges -> outputs zero immediately; after release with mode=1 and req=8'h88 -> gnt_code=3.
REQ-030 SHALL be verified with the following scenario: mode toggled 0->1 while a grant is held with code=1 -> the grant is unchanged until ack; with req=8'h03 at ack, the next winner is 0 under round-robin from ptr=2 (wrapping), not under fixed mode.
